// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter_pkg
//  Purpose  : Shared types and helpers for the data-memory arbiter: the
//             arbiter state encoding and the pointer-width helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

    localparam int STATE_BITS = 3;

    typedef enum logic [STATE_BITS-1:0] {
        IDLE           = 3'd0,
        READ_WAITING   = 3'd1,
        WRITE_WAITING  = 3'd2,
        READ_RELAYING  = 3'd3,
        WRITE_RELAYING = 3'd4
    } state_e;

    // Width of a consumer index; a single consumer still needs one bit.
    function automatic int ptr_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : dmem_arbiter_pkg
`default_nettype wire

// File: rtl/dmem_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module   : rr_picker
//  Purpose  : Round-robin request picker. Scans the request vector starting
//             at rr_ptr, wrapping from NUM_CONSUMERS-1 back to 0, and reports
//             the first requester found.
//  Ports    : req     - one request bit per consumer
//             rr_ptr  - index where the scan begins
//             found   - at least one request is pending
//             index   - first requesting consumer at or after rr_ptr
//  Revision : 1.0 - initial release
// ============================================================================
module rr_picker #(
    parameter int NUM_CONSUMERS = 4,
    parameter int PTR_BITS      = 2
) (
    input  logic [NUM_CONSUMERS-1:0] req,
    input  logic [PTR_BITS-1:0]      rr_ptr,
    output logic                     found,
    output logic [PTR_BITS-1:0]      index
);

    int                  cand;
    logic [PTR_BITS-1:0] cand_idx;

    // Walk the scan order backwards so the last hit written is the one
    // closest to rr_ptr.
    always_comb begin
        found    = 1'b0;
        index    = '0;
        cand     = 0;
        cand_idx = '0;
        for (int i = NUM_CONSUMERS - 1; i >= 0; i--) begin
            cand = int'(rr_ptr) + i;
            if (cand >= NUM_CONSUMERS) begin
                cand = cand - NUM_CONSUMERS;
            end
            cand_idx = PTR_BITS'(cand);
            if (req[cand_idx]) begin
                found = 1'b1;
                index = cand_idx;
            end
        end
    end

endmodule : rr_picker
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Shares one memory read/write channel between NUM_CONSUMERS
//             load/store units with round-robin fairness. One transaction is
//             in flight at a time: grant, wait for memory, relay completion
//             until the consumer withdraws its request.
//  Ports    : clk, reset (async, active low)
//             consumer_read/write_valid, _address, consumer_write_data (in)
//             consumer_read/write_ready, consumer_read_data            (out)
//             mem_read/write_valid, _address, mem_write_data           (out)
//             mem_read/write_ready, mem_read_data                      (in)
//             busy - arbiter is not idle
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int NUM_CONSUMERS = 4,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,
    output logic                                     mem_read_valid,
    output logic [ADDR_BITS-1:0]                     mem_read_address,
    input  logic                                     mem_read_ready,
    input  logic [DATA_BITS-1:0]                     mem_read_data,
    output logic                                     mem_write_valid,
    output logic [ADDR_BITS-1:0]                     mem_write_address,
    output logic [DATA_BITS-1:0]                     mem_write_data,
    input  logic                                     mem_write_ready,
    output logic                                     busy
);

    localparam int                  PTR_BITS = ptr_bits(NUM_CONSUMERS);
    localparam logic [PTR_BITS-1:0] LAST_IDX = PTR_BITS'(NUM_CONSUMERS - 1);

    state_e                                 state_q, state_d;
    logic [PTR_BITS-1:0]                    rr_ptr_q, rr_ptr_d;
    logic [PTR_BITS-1:0]                    grant_q, grant_d;
    logic                                   mem_read_valid_q, mem_read_valid_d;
    logic [ADDR_BITS-1:0]                   mem_read_address_q, mem_read_address_d;
    logic                                   mem_write_valid_q, mem_write_valid_d;
    logic [ADDR_BITS-1:0]                   mem_write_address_q, mem_write_address_d;
    logic [DATA_BITS-1:0]                   mem_write_data_q, mem_write_data_d;
    logic [NUM_CONSUMERS-1:0]               rd_ready_q, rd_ready_d;
    logic [NUM_CONSUMERS-1:0]               wr_ready_q, wr_ready_d;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] rd_data_q, rd_data_d;

    logic [NUM_CONSUMERS-1:0] pick_req;
    logic                     pick_found;
    logic [PTR_BITS-1:0]      pick_idx;

    assign pick_req = consumer_read_valid | consumer_write_valid;

    rr_picker #(
        .NUM_CONSUMERS (NUM_CONSUMERS),
        .PTR_BITS      (PTR_BITS)
    ) u_rr_picker (
        .req    (pick_req),
        .rr_ptr (rr_ptr_q),
        .found  (pick_found),
        .index  (pick_idx)
    );

    always_comb begin
        state_d             = state_q;
        rr_ptr_d            = rr_ptr_q;
        grant_d             = grant_q;
        mem_read_valid_d    = mem_read_valid_q;
        mem_read_address_d  = mem_read_address_q;
        mem_write_valid_d   = mem_write_valid_q;
        mem_write_address_d = mem_write_address_q;
        mem_write_data_d    = mem_write_data_q;
        rd_ready_d          = rd_ready_q;
        wr_ready_d          = wr_ready_q;
        rd_data_d           = rd_data_q;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    // A consumer asking for both gets its read first; the
                    // write stays pending and competes on a later scan.
                    if (consumer_read_valid[pick_idx]) begin
                        mem_read_valid_d   = 1'b1;
                        mem_read_address_d = consumer_read_address[pick_idx];
                        state_d            = READ_WAITING;
                    end else begin
                        mem_write_valid_d   = 1'b1;
                        mem_write_address_d = consumer_write_address[pick_idx];
                        mem_write_data_d    = consumer_write_data[pick_idx];
                        state_d             = WRITE_WAITING;
                    end
                end
            end

            READ_WAITING: begin
                if (mem_read_ready) begin
                    mem_read_valid_d   = 1'b0;
                    rd_data_d[grant_q] = mem_read_data;
                    rd_ready_d[grant_q] = 1'b1;
                    state_d            = READ_RELAYING;
                end
            end

            WRITE_WAITING: begin
                if (mem_write_ready) begin
                    mem_write_valid_d   = 1'b0;
                    wr_ready_d[grant_q] = 1'b1;
                    state_d             = WRITE_RELAYING;
                end
            end

            READ_RELAYING: begin
                if (!consumer_read_valid[grant_q]) begin
                    rd_ready_d = '0;
                    rr_ptr_d   = (grant_q == LAST_IDX) ? '0 : grant_q + PTR_BITS'(1);
                    state_d    = IDLE;
                end
            end

            WRITE_RELAYING: begin
                if (!consumer_write_valid[grant_q]) begin
                    wr_ready_d = '0;
                    rr_ptr_d   = (grant_q == LAST_IDX) ? '0 : grant_q + PTR_BITS'(1);
                    state_d    = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q             <= IDLE;
            rr_ptr_q            <= '0;
            grant_q             <= '0;
            mem_read_valid_q    <= 1'b0;
            mem_read_address_q  <= '0;
            mem_write_valid_q   <= 1'b0;
            mem_write_address_q <= '0;
            mem_write_data_q    <= '0;
            rd_ready_q          <= '0;
            wr_ready_q          <= '0;
            rd_data_q           <= '0;
        end else begin
            state_q             <= state_d;
            rr_ptr_q            <= rr_ptr_d;
            grant_q             <= grant_d;
            mem_read_valid_q    <= mem_read_valid_d;
            mem_read_address_q  <= mem_read_address_d;
            mem_write_valid_q   <= mem_write_valid_d;
            mem_write_address_q <= mem_write_address_d;
            mem_write_data_q    <= mem_write_data_d;
            rd_ready_q          <= rd_ready_d;
            wr_ready_q          <= wr_ready_d;
            rd_data_q           <= rd_data_d;
        end
    end

    assign consumer_read_ready  = rd_ready_q;
    assign consumer_write_ready = wr_ready_q;
    assign consumer_read_data   = rd_data_q;
    assign mem_read_valid       = mem_read_valid_q;
    assign mem_read_address     = mem_read_address_q;
    assign mem_write_valid      = mem_write_valid_q;
    assign mem_write_address    = mem_write_address_q;
    assign mem_write_data       = mem_write_data_q;
    // Decoded from the state register so reset clears it without a clock.
    assign busy                 = (state_q != IDLE);

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_arbiter
//  Purpose  : Self-checking bench for dmem_arbiter: transaction-level model
//             compared every cycle, plus directed scenarios with literal
//             expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int N  = 4;
    localparam int AB = 8;
    localparam int DB = 8;

    logic clk = 1'b0;
    logic reset;

    logic [N-1:0]         c_rv, c_wv;
    logic [N-1:0][AB-1:0] c_raddr, c_waddr;
    logic [N-1:0][DB-1:0] c_wdata;
    logic [N-1:0]         c_rready, c_wready;
    logic [N-1:0][DB-1:0] c_rdata;
    logic                 m_rvalid, m_wvalid;
    logic [AB-1:0]        m_raddr, m_waddr;
    logic [DB-1:0]        m_wdata;
    logic                 m_rready, m_wready;
    logic [DB-1:0]        m_rdata;
    logic                 busy;

    logic          auto_rready, auto_wready, man_rready;
    logic [DB-1:0] auto_rdata, man_rdata;

    assign m_rready = auto_rready | man_rready;
    assign m_rdata  = man_rready ? man_rdata : auto_rdata;
    assign m_wready = auto_wready;

    dmem_arbiter #(.NUM_CONSUMERS(N), .ADDR_BITS(AB), .DATA_BITS(DB)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .consumer_read_valid    (c_rv),
        .consumer_read_address  (c_raddr),
        .consumer_read_ready    (c_rready),
        .consumer_read_data     (c_rdata),
        .consumer_write_valid   (c_wv),
        .consumer_write_address (c_waddr),
        .consumer_write_data    (c_wdata),
        .consumer_write_ready   (c_wready),
        .mem_read_valid         (m_rvalid),
        .mem_read_address       (m_raddr),
        .mem_read_ready         (m_rready),
        .mem_read_data          (m_rdata),
        .mem_write_valid        (m_wvalid),
        .mem_write_address      (m_waddr),
        .mem_write_data         (m_wdata),
        .mem_write_ready        (m_wready),
        .busy                   (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    bit started  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: timed out waiting, got no event expected one", name);
    endtask

    // ---------------- memory responder ----------------
    int            rd_lat = 1, wr_lat = 1;
    logic [DB-1:0] rd_xor = '0;

    initial begin
        int rd_cnt;
        int wr_cnt;
        rd_cnt = 0; wr_cnt = 0;
        auto_rready = 1'b0; auto_wready = 1'b0; auto_rdata = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                rd_cnt = 0; wr_cnt = 0; auto_rready = 1'b0; auto_wready = 1'b0;
            end else begin
                if (auto_rready) auto_rready = 1'b0;
                else if (m_rvalid) begin
                    rd_cnt++;
                    if (rd_cnt >= rd_lat) begin
                        auto_rready = 1'b1;
                        auto_rdata  = m_raddr ^ rd_xor;
                        rd_cnt      = 0;
                    end
                end
                if (auto_wready) auto_wready = 1'b0;
                else if (m_wvalid) begin
                    wr_cnt++;
                    if (wr_cnt >= wr_lat) begin
                        auto_wready = 1'b1;
                        wr_cnt      = 0;
                    end
                end
            end
        end
    end

    // ---------------- transaction-level model ----------------
    int                   owner;      // -1 when the channel is free
    bit                   owner_wr;
    bit                   answered;
    int                   next_start;
    bit                   e_rvalid, e_wvalid;
    logic [AB-1:0]        e_raddr, e_waddr;
    logic [DB-1:0]        e_wdata;
    logic [N-1:0][DB-1:0] e_rdata;
    int                   grant_log[$];

    task automatic mdl_reset();
        owner = -1; owner_wr = 0; answered = 0; next_start = 0;
        e_rvalid = 0; e_wvalid = 0; e_raddr = '0; e_waddr = '0; e_wdata = '0;
        e_rdata = '0;
    endtask

    task automatic mdl_step();
        if (owner < 0) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (next_start + k) % N;
                if (owner < 0 && (c_rv[c] || c_wv[c])) begin
                    owner    = c;
                    owner_wr = !c_rv[c];
                    answered = 0;
                    if (!owner_wr) begin
                        e_rvalid = 1; e_raddr = c_raddr[c];
                    end else begin
                        e_wvalid = 1; e_waddr = c_waddr[c]; e_wdata = c_wdata[c];
                    end
                    grant_log.push_back(c + (owner_wr ? 10 : 0));
                end
            end
        end else if (!answered) begin
            if (!owner_wr && m_rready) begin
                e_rvalid = 0; e_rdata[owner] = m_rdata; answered = 1;
            end else if (owner_wr && m_wready) begin
                e_wvalid = 0; answered = 1;
            end
        end else begin
            if ((!owner_wr && !c_rv[owner]) || (owner_wr && !c_wv[owner])) begin
                next_start = (owner + 1) % N;
                owner      = -1;
            end
        end
    endtask

    task automatic mdl_compare();
        logic [N-1:0] exp_rr, exp_wr;
        exp_rr = '0; exp_wr = '0;
        if (owner >= 0 && answered) begin
            if (owner_wr) exp_wr[owner] = 1'b1;
            else          exp_rr[owner] = 1'b1;
        end
        check("cyc busy",              32'(busy),     32'(owner >= 0));
        check("cyc mem_read_valid",    32'(m_rvalid), 32'(e_rvalid));
        check("cyc mem_read_address",  32'(m_raddr),  32'(e_raddr));
        check("cyc mem_write_valid",   32'(m_wvalid), 32'(e_wvalid));
        check("cyc mem_write_address", 32'(m_waddr),  32'(e_waddr));
        check("cyc mem_write_data",    32'(m_wdata),  32'(e_wdata));
        check("cyc consumer_read_ready",  32'(c_rready), 32'(exp_rr));
        check("cyc consumer_write_ready", 32'(c_wready), 32'(exp_wr));
        check("cyc consumer_read_data",   32'(c_rdata),  32'(e_rdata));
    endtask

    initial begin
        mdl_reset();
        wait (started);
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) mdl_reset();
            else        mdl_step();
            #1;
            mdl_compare();
        end
    end

    // ---------------- stimulus helpers ----------------
    int log_pos = 0;

    task automatic check_log(input string name, input int exp);
        if (log_pos < grant_log.size()) check(name, 32'(grant_log[log_pos]), 32'(exp));
        else fail_timeout(name);
        log_pos++;
    endtask

    task automatic clear_inputs();
        c_rv = '0; c_wv = '0; c_raddr = '0; c_waddr = '0; c_wdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic serve(input int n, input string name);
        int done, cyc;
        done = 0; cyc = 0;
        while (done < n && cyc < 200) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < N; i++) begin
                if (c_rready[i] && c_rv[i]) begin c_rv[i] = 1'b0; done++; end
                if (c_wready[i] && c_wv[i]) begin c_wv[i] = 1'b0; done++; end
            end
        end
        if (done < n) fail_timeout(name);
    endtask

    task automatic wait_idle(input string name);
        int cyc;
        cyc = 0;
        while (busy && cyc < 50) begin @(negedge clk); cyc++; end
        if (busy) fail_timeout(name);
    endtask

    task automatic wait_busy(input string name);
        int cyc;
        cyc = 0;
        while (!busy && cyc < 50) begin @(negedge clk); cyc++; end
        if (!busy) fail_timeout(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int hi_cnt;
        reset = 1'b0;
        man_rready = 1'b0; man_rdata = '0;
        clear_inputs();
        started = 1'b1;

        @(negedge clk);
        check("reset busy",           32'(busy),     32'd0);
        check("reset mem_read_valid", 32'(m_rvalid), 32'd0);
        check("reset read_ready",     32'(c_rready), 32'd0);
        check("reset read_data",      32'(c_rdata),  32'd0);
        reset = 1'b1;

        // Consumer 2 reads 0x10, memory answers after 2 cycles with 0xAB.
        rd_lat = 2; rd_xor = 8'hBB;
        c_raddr[2] = 8'h10; c_rv[2] = 1'b1;
        serve(1, "c2 read");
        wait_idle("c2 idle");
        check("c2 mem_read_address", 32'(m_raddr),    32'h10);
        check("c2 read_data",        32'(c_rdata[2]), 32'hAB);
        check("c2 busy",             32'(busy),       32'd0);
        check_log("c2 grant", 2);

        // All four read together from a fresh reset: order 0,1,2,3.
        do_reset();
        rd_lat = 1; rd_xor = 8'h0F;
        for (int i = 0; i < N; i++) c_raddr[i] = 8'(8'h40 + i);
        c_rv = 4'hF;
        serve(4, "all read");
        wait_idle("all idle");
        check_log("all grant0", 0);
        check_log("all grant1", 1);
        check_log("all grant2", 2);
        check_log("all grant3", 3);
        check("all read_data0", 32'(c_rdata[0]), 32'h4F);
        check("all read_data3", 32'(c_rdata[3]), 32'h4C);

        // Pointer wrapped to 0: consumers 3 and 0 -> 0 first.
        c_raddr[0] = 8'h50; c_raddr[3] = 8'h53; c_rv = 4'b1001;
        serve(2, "wrap read");
        wait_idle("wrap idle");
        check_log("wrap grant0", 0);
        check_log("wrap grant3", 3);

        // Consumer 1 read and write together: read then write.
        c_raddr[1] = 8'h21; c_waddr[1] = 8'h20; c_wdata[1] = 8'h5A;
        c_rv[1] = 1'b1; c_wv[1] = 1'b1;
        serve(2, "rw c1");
        wait_idle("rw idle");
        check_log("rw read first", 1);
        check_log("rw write next", 11);
        check("rw mem_write_address", 32'(m_waddr), 32'h20);
        check("rw mem_write_data",    32'(m_wdata), 32'h5A);

        // Consumer 0 drops its read while waiting on memory.
        rd_lat = 3;
        c_raddr[0] = 8'h33; c_rv[0] = 1'b1;
        wait_busy("drop grant");
        c_rv[0] = 1'b0;
        hi_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (c_rready[0]) hi_cnt++;
        end
        check("drop ready cycles", 32'(hi_cnt),     32'd1);
        check("drop busy",         32'(busy),       32'd0);
        check("drop read_data0",   32'(c_rdata[0]), 32'h3C);
        check_log("drop grant", 0);

        // Stray memory ready while idle is ignored.
        @(negedge clk);
        man_rdata = 8'hEE; man_rready = 1'b1;
        @(negedge clk);
        man_rready = 1'b0;
        check("stray busy",       32'(busy),       32'd0);
        check("stray read_ready", 32'(c_rready),   32'd0);
        check("stray read_data0", 32'(c_rdata[0]), 32'h3C);

        // Reset in the middle of a read wait.
        rd_lat = 6;
        c_raddr[0] = 8'h77; c_rv[0] = 1'b1;
        wait_busy("midrst grant");
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst mem_read_valid", 32'(m_rvalid), 32'd0);
        check("midrst busy",           32'(busy),     32'd0);
        clear_inputs();
        repeat (2) @(negedge clk);
        rd_lat = 1;
        c_raddr[0] = 8'h70; c_raddr[3] = 8'h03; c_rv = 4'b1001;
        reset = 1'b1;
        serve(2, "midrst serve");
        wait_idle("midrst idle");
        check_log("midrst aborted", 0);
        check_log("midrst first", 0);
        check_log("midrst second", 3);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule : tb_dmem_arbiter
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter NUM_CONSUMERS, default 4, SHALL set the number of LSU requesters sharing one memory channel.
REQ-002 Parameter ADDR_BITS, default 8, SHALL set the memory address width.
REQ-003 Parameter DATA_BITS, default 8, SHALL set the memory data width.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-005 reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-006 consumer_read_valid / consumer_write_valid  input  [NUM_CONSUMERS]  SHALL carry per-LSU read / write requests.
REQ-007 consumer_read_address, consumer_write_address  input  [NUM_CONSUMERS][ADDR_BITS]  SHALL carry request addresses.
REQ-008 consumer_write_data  input  [NUM_CONSUMERS][DATA_BITS]  SHALL carry write data.
REQ-009 consumer_read_ready / consumer_write_ready  output  [NUM_CONSUMERS]  SHALL signal completion to the granted LSU.
REQ-010 consumer_read_data  output  [NUM_CONSUMERS][DATA_BITS]  SHALL return read data per LSU.
REQ-011 mem_read_valid, mem_write_valid  output  1; mem_read_address, mem_write_address  output  ADDR_BITS; mem_write_data  output  DATA_BITS  SHALL drive the memory channel.
REQ-012 mem_read_ready, mem_write_ready  input  1; mem_read_data  input  DATA_BITS  SHALL be the memory responses.
REQ-013 busy  output  1  SHALL be high whenever state is not IDLE.

Function
REQ-014 FSM states SHALL be IDLE=0, READ_WAITING=1, WRITE_WAITING=2, READ_RELAYING=3, WRITE_RELAYING=4.
REQ-015 IDLE: SHALL scan consumers from rr_ptr upward, wrapping at NUM_CONSUMERS-1 to 0, and grant the first with read_valid or write_valid.
REQ-016 Same consumer with read_valid and write_valid both high: read SHALL be granted; write remains pending.
REQ-017 On the grant edge, address (and write data) SHALL be latched, mem_*_valid SHALL rise, state -> *_WAITING; grant index stored.
REQ-018 *_WAITING: mem_*_valid and mem_* address/data SHALL hold stable until mem_*_ready is sampled high.
REQ-019 On the edge mem_read_ready is sampled high: mem_read_valid falls, mem_read_data latched into consumer_read_data[grant], consumer_read_ready[grant] rises, state -> READ_RELAYING; write analogous without data.
REQ-020 *_RELAYING: consumer_*_ready[grant] SHALL hold until consumer_*_valid[grant] sampled low; then ready falls, rr_ptr <= (grant+1) mod NUM_CONSUMERS, state -> IDLE.
REQ-021 At most one consumer_*_ready bit SHALL be high in any cycle; non-granted consumer_read_data SHALL hold last value.
REQ-022 Consumer valid dropping during *_WAITING SHALL NOT abort; transaction completes and ready pulses one cycle.
REQ-023 mem_*_ready high while not in the matching WAITING state SHALL be ignored.
REQ-024 Latency: grant to mem valid 0 cycles (same edge); mem ready to consumer ready 1 edge; minimum 3 edges per transaction from IDLE back to IDLE.

Reset
REQ-025 reset low SHALL immediately force state IDLE, rr_ptr 0, all mem_* and consumer_* outputs 0, busy 0, independent of clk.
REQ-026 Reset mid-transaction SHALL discard the in-flight request; first grant after release SHALL scan from consumer 0.

Structure
REQ-027 A shared package dmem_arbiter_pkg SHALL hold the state enum and its 3-bit encodings.
REQ-028 Round-robin selection SHALL live in sub-module rr_picker (inputs request vector, rr_ptr; outputs found, index).

Verification
REQ-029 Reset then consumer 2 read @0x10, memory ready after 2 cycles returning 0xAB -> mem_read_address 0x10, consumer_read_data[2]=0xAB, consumer_read_ready[2] one relay phase, busy back to 0.
REQ-030 All four consumers assert read simultaneously, memory ready in 1 cycle -> grant order 0,1,2,3; after 3, rr_ptr wraps to 0.
REQ-031 Consumer 1 read and write both valid -> read serviced first, write (addr 0x20, data 0x5A) next grant with mem_write_address 0x20, mem_write_data 0x5A.
REQ-032 Consumer 0 drops read_valid during READ_WAITING -> transaction completes, ready high exactly one cycle, FSM returns IDLE.
REQ-033 Assert reset low mid READ_WAITING -> mem_read_valid and busy 0 immediately; after release, consumer 3 and 0 requests -> 0 granted first.
REQ-034 Stray mem_read_ready pulse in IDLE -> no state change, no consumer ready.
